// File: rtl/remote_calc_if.sv
// remote_calc_if: key strobe from the IR receiver in, display digits and status out
interface remote_calc_if;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       power_on;
  logic       busy;
  logic [3:0] a_tens;
  logic [3:0] a_units;
  logic       a_neg;
  logic [3:0] b_tens;
  logic [3:0] b_units;
  logic       b_neg;
  logic       op_sub;
  logic       ovf;
  modport master (
    output cmd_valid, cmd,
    input  power_on, busy, a_tens, a_units, a_neg, b_tens, b_units, b_neg, op_sub, ovf
  );
  modport slave (
    input  cmd_valid, cmd,
    output power_on, busy, a_tens, a_units, a_neg, b_tens, b_units, b_neg, op_sub, ovf
  );
endinterface

// File: rtl/remote_calc.sv
// remote_calc: two-operand signed calculator driven by decoded IR key bytes, BCD display outputs
module remote_calc #(
  parameter logic [7:0] KEY_POWER = 8'h12,
  parameter logic [7:0] KEY_CLR_A = 8'h0F,
  parameter logic [7:0] KEY_CLR_B = 8'h13,
  parameter logic [7:0] KEY_CLR   = 8'h10,
  parameter logic [7:0] KEY_ADD   = 8'h1A,
  parameter logic [7:0] KEY_SUB   = 8'h1E,
  parameter logic [7:0] KEY_NEG   = 8'h0C
) (
  input logic         clk,
  input logic         rst_n,
  remote_calc_if.slave bus
);
  typedef enum logic [2:0] {OFF, ENTER_A, ENTER_B, CALC, CONV} state_t;
  state_t     state_q;
  logic       power_q, busy_q, a_neg_q, b_neg_q, op_sub_q, calc_sub_q, ovf_q, res_neg_q;
  logic [7:0] a_q, b_q, bcd_q;
  logic [6:0] bin_q;
  logic [2:0] cnt_q;
  logic [6:0] a_mag, b_mag, mag;
  logic [8:0] sa, sb, r, r_mag;
  logic       sat, power_key, entering, in_a, is_digit;
  logic [3:0] d, adj_u, adj_t;
  logic [7:0] bcd_n;
  // Operand values, signed result with saturation, and one shift-add-3 step
  always_comb begin
    power_key = bus.cmd_valid && bus.cmd == KEY_POWER;
    entering  = state_q == ENTER_A || state_q == ENTER_B;
    in_a      = state_q == ENTER_A;
    is_digit  = bus.cmd < 8'd10;
    d         = bus.cmd[3:0];
    a_mag     = 7'(a_q[7:4]) * 7'd10 + 7'(a_q[3:0]);
    b_mag     = 7'(b_q[7:4]) * 7'd10 + 7'(b_q[3:0]);
    sa        = a_neg_q ? -{2'b00, a_mag} : {2'b00, a_mag};
    sb        = b_neg_q ? -{2'b00, b_mag} : {2'b00, b_mag};
    r         = calc_sub_q ? sa - sb : sa + sb;
    r_mag     = r[8] ? -r : r;
    sat       = r_mag > 9'd99;
    mag       = sat ? 7'd99 : r_mag[6:0];
    adj_u     = bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj_t     = bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bcd_n     = 8'({adj_t, adj_u, bin_q[6]});
  end
  // Calculator FSM: power toggle, operand entry, clears, one-cycle calc then 7-step BCD conversion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= OFF;
      power_q    <= 1'b0;
      busy_q     <= 1'b0;
      a_q        <= 8'hFF;
      b_q        <= 8'hFF;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      op_sub_q   <= 1'b0;
      calc_sub_q <= 1'b0;
      ovf_q      <= 1'b0;
      res_neg_q  <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
    end else if (power_key) begin
      state_q  <= state_q == OFF ? ENTER_A : OFF;
      power_q  <= state_q == OFF;
      busy_q   <= 1'b0;
      a_q      <= state_q == OFF ? 8'h00 : 8'hFF;
      b_q      <= state_q == OFF ? 8'h00 : 8'hFF;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      op_sub_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.cmd_valid && entering) begin
      if (is_digit) begin
        if (in_a) begin
          a_q     <= {a_q[3:0], d};
          a_neg_q <= a_neg_q && {a_q[3:0], d} != 8'h00;
        end else begin
          b_q     <= {b_q[3:0], d};
          b_neg_q <= b_neg_q && {b_q[3:0], d} != 8'h00;
        end
      end else if (bus.cmd == KEY_NEG) begin
        if (in_a) a_neg_q <= !a_neg_q && a_q != 8'h00;
        else      b_neg_q <= !b_neg_q && b_q != 8'h00;
      end else if (bus.cmd == KEY_ADD || bus.cmd == KEY_SUB) begin
        op_sub_q <= bus.cmd == KEY_SUB;
        if (in_a) begin
          state_q <= ENTER_B;
          b_q     <= 8'h00;
          b_neg_q <= 1'b0;
        end else begin
          calc_sub_q <= op_sub_q;
          state_q    <= CALC;
          busy_q     <= 1'b1;
        end
      end else if (bus.cmd == KEY_CLR_A) begin
        a_q     <= 8'h00;
        a_neg_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (bus.cmd == KEY_CLR_B) begin
        b_q     <= 8'h00;
        b_neg_q <= 1'b0;
      end else if (bus.cmd == KEY_CLR) begin
        state_q  <= ENTER_A;
        a_q      <= 8'h00;
        b_q      <= 8'h00;
        a_neg_q  <= 1'b0;
        b_neg_q  <= 1'b0;
        op_sub_q <= 1'b0;
        ovf_q    <= 1'b0;
      end
    end else if (state_q == CALC) begin
      bin_q     <= mag;
      res_neg_q <= r[8];
      ovf_q     <= ovf_q | sat;
      bcd_q     <= '0;
      cnt_q     <= '0;
      state_q   <= CONV;
    end else if (state_q == CONV) begin
      bcd_q <= bcd_n;
      bin_q <= {bin_q[5:0], 1'b0};
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        a_q     <= bcd_n;
        a_neg_q <= res_neg_q;
        b_q     <= 8'h00;
        b_neg_q <= 1'b0;
        busy_q  <= 1'b0;
        state_q <= ENTER_B;
      end
    end
  assign bus.power_on = power_q;
  assign bus.busy     = busy_q;
  assign bus.a_tens   = a_q[7:4];
  assign bus.a_units  = a_q[3:0];
  assign bus.a_neg    = a_neg_q;
  assign bus.b_tens   = b_q[7:4];
  assign bus.b_units  = b_q[3:0];
  assign bus.b_neg    = b_neg_q;
  assign bus.op_sub   = op_sub_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_remote_calc.sv
// tb_remote_calc: table-driven vectors plus hand sequences, results checked through a scoreboard queue
module tb_remote_calc;
  localparam logic [7:0] K_POWER = 8'h12, K_CLR_A = 8'h0F, K_CLR = 8'h10,
                         K_ADD = 8'h1A, K_SUB = 8'h1E, K_NEG = 8'h0C, K_BAD = 8'h55;
  logic clk = 1'b0;
  logic rst_n;
  remote_calc_if bus();
  remote_calc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a; logic an; logic [7:0] b; logic bn; logic sub;
    logic [7:0] r; logic rn; logic ovf;
  } vec_t;
  typedef struct { logic [7:0] a; logic an; logic op; logic ovf; } res_t;
  vec_t vt[11];
  res_t sb[$];
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [7:0] a, input logic an, input logic [7:0] b,
                     input logic bn, input logic op, input logic ovf, input logic pwr, input logic bsy);
    logic [21:0] got, exp;
    got = {bus.a_tens, bus.a_units, bus.a_neg, bus.b_tens, bus.b_units, bus.b_neg,
           bus.op_sub, bus.ovf, bus.power_on, bus.busy};
    exp = {a, an, b, bn, op, ovf, pwr, bsy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got A=%h neg=%b B=%h neg=%b op=%b ovf=%b pwr=%b busy=%b, want A=%h neg=%b B=%h neg=%b op=%b ovf=%b pwr=%b busy=%b",
               nm, got[21:14], got[13], got[12:5], got[4], got[3], got[2], got[1], got[0],
               a, an, b, bn, op, ovf, pwr, bsy);
    end
  endtask
  task automatic press(input logic [7:0] k);
    bus.cmd_valid = 1'b1;
    bus.cmd = k;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic enter(input logic [7:0] v);
    press({4'h0, v[7:4]});
    press({4'h0, v[3:0]});
  endtask
  task automatic start_exec(input logic [7:0] k, input res_t e);
    sb.push_back(e);
    press(k);
  endtask
  task automatic finish_exec(input int nb);
    int n = 0;
    res_t e;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != nb) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, want %0d", n, nb);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result with no expected entry");
    end else begin
      checks--;
      e = sb.pop_front();
      chk("result", e.a, e.an, 8'h00, 1'b0, e.op, e.ovf, 1'b1, 1'b0);
    end
  endtask
  initial begin
    vt = '{
      '{8'h75, 1'b0, 8'h30, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1},
      '{8'h12, 1'b0, 8'h40, 1'b0, 1'b1, 8'h28, 1'b1, 1'b0},
      '{8'h12, 1'b1, 8'h40, 1'b0, 1'b0, 8'h28, 1'b0, 1'b0},
      '{8'h50, 1'b1, 8'h49, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0},
      '{8'h50, 1'b1, 8'h49, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0},
      '{8'h33, 1'b0, 8'h33, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0},
      '{8'h99, 1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b1},
      '{8'h09, 1'b0, 8'h90, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0},
      '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0},
      '{8'h64, 1'b0, 8'h35, 1'b1, 1'b0, 8'h29, 1'b0, 1'b0},
      '{8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0}
    };
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_held", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_off", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    press(K_POWER);
    chk("power_on", 8'h00, 0, 8'h00, 0, 0, 0, 1, 0);
    press(K_POWER);
    chk("power_off", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    press(K_BAD);
    chk("bad_off", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    press(K_POWER);
    press(8'h04); press(8'h07); press(8'h05);
    chk("a_shift", 8'h75, 0, 8'h00, 0, 0, 0, 1, 0);
    press(K_ADD); enter(8'h30);
    chk("b_entry", 8'h75, 0, 8'h30, 0, 0, 0, 1, 0);
    start_exec(K_ADD, '{8'h99, 1'b0, 1'b0, 1'b1});
    finish_exec(8);
    enter(8'h12);
    press(K_CLR_A);
    chk("clr_a_ovf", 8'h00, 0, 8'h12, 0, 0, 0, 1, 0);
    press(K_CLR); enter(8'h12); press(K_SUB); enter(8'h40);
    start_exec(K_SUB, '{8'h28, 1'b1, 1'b1, 1'b0});
    finish_exec(8);
    press(K_NEG);
    chk("neg_b_zero", 8'h28, 1, 8'h00, 0, 1, 0, 1, 0);
    enter(8'h28);
    start_exec(K_ADD, '{8'h56, 1'b1, 1'b0, 1'b0});
    finish_exec(8);
    enter(8'h56);
    start_exec(K_SUB, '{8'h00, 1'b0, 1'b1, 1'b0});
    finish_exec(8);
    press(K_CLR); press(K_NEG);
    chk("neg_a_zero", 8'h00, 0, 8'h00, 0, 0, 0, 1, 0);
    enter(8'h42); press(K_BAD);
    chk("bad_enter_a", 8'h42, 0, 8'h00, 0, 0, 0, 1, 0);
    press(K_CLR); enter(8'h20); press(K_ADD); enter(8'h15);
    start_exec(K_ADD, '{8'h35, 1'b0, 1'b0, 1'b0});
    press(8'h09); press(K_BAD);
    finish_exec(6);
    press(8'h01); press(8'h02); press(8'h03);
    chk("back_to_back", 8'h35, 0, 8'h23, 0, 0, 0, 1, 0);
    press(K_BAD);
    chk("bad_enter_b", 8'h35, 0, 8'h23, 0, 0, 0, 1, 0);
    press(K_ADD);
    repeat (3) @(negedge clk);
    press(K_POWER);
    chk("power_abort", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    press(K_POWER); press(8'h05); press(K_ADD); press(8'h05); press(K_ADD);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_conv", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0);
    press(K_POWER);
    for (int i = 0; i < 11; i++) begin
      press(K_CLR);
      enter(vt[i].a);
      if (vt[i].an) press(K_NEG);
      press(vt[i].sub ? K_SUB : K_ADD);
      enter(vt[i].b);
      if (vt[i].bn) press(K_NEG);
      start_exec(K_ADD, '{vt[i].r, vt[i].rn, 1'b0, vt[i].ovf});
      finish_exec(8);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
